dft_mac_engine: RTL and testbench

- Parametrised direct-DFT compute engine: for a frame of N complex samples it produces X[k] = sum over n of x[n]·W_N^(k·n) for k = 0..N-1.
- Sequences sample and twiddle RAM addresses, runs a pipelined complex multiply with rounding, and accumulates each bin.
- Presents each finished bin on a valid/ready output to the AXI write bridge.
- Sits between sample RAM / twiddle ROM and the bridge. It replaces the free-standing multiplier, rounding and accumulator instances with one controlled datapath.

---
 rtl/dft_pkg.sv | 28 ++
 rtl/cmul_round.sv | 80 ++++++++
 rtl/dft_mac_engine.sv | 165 ++++++++++++++++
 tb/tb_dft_mac_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared types, default widths and the rounding helper for the direct-DFT engine.
package dft_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int TW_W_DEF      = 16;
  localparam int FRAC_BITS_DEF = 15;
  localparam int ACC_W_DEF     = 36;
  localparam int ADDR_W_DEF    = 12;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] re;
    logic signed [ACC_W_DEF-1:0] im;
  } cplx_t;

  // Half an LSB of the rounded result, giving round-half-up after the shift.
  function automatic longint round_offset(input int frac_bits);
    return (frac_bits > 0) ? (longint'(1) <<< (frac_bits - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Registered complex multiply (operand stage, product stage) followed by a
// round-half-up stage; valid and first-term flags travel with the data.
module cmul_round
  import dft_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TW_W      = TW_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    n_Reset,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic [2*DATA_W-1:0]     i_x,
  input  logic [2*TW_W-1:0]       i_w,
  output logic                    o_valid,
  output logic                    o_first,
  output logic                    o_busy,
  output logic signed [ACC_W-1:0] o_re,
  output logic signed [ACC_W-1:0] o_im
);

  localparam int PW = DATA_W + TW_W;
  localparam logic signed [PW+1:0] RND_OFS = (PW+2)'(round_offset(FRAC_BITS));

  logic signed [DATA_W-1:0] r_xr, r_xi;
  logic signed [TW_W-1:0]   r_wr, r_wi;
  logic signed [PW-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic                     r_va, r_fa, r_vb, r_fb;

  logic signed [PW+1:0] w_re_ofs, w_im_ofs, w_re_sh, w_im_sh;

  // Two guard bits keep the product difference plus offset from wrapping.
  assign w_re_ofs = (PW+2)'(r_p_rr) - (PW+2)'(r_p_ii) + RND_OFS;
  assign w_im_ofs = (PW+2)'(r_p_ri) + (PW+2)'(r_p_ir) + RND_OFS;
  assign w_re_sh  = w_re_ofs >>> FRAC_BITS;
  assign w_im_sh  = w_im_ofs >>> FRAC_BITS;

  assign o_busy = r_va | r_vb;

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      r_xr    <= '0;
      r_xi    <= '0;
      r_wr    <= '0;
      r_wi    <= '0;
      r_va    <= 1'b0;
      r_fa    <= 1'b0;
      r_p_rr  <= '0;
      r_p_ii  <= '0;
      r_p_ri  <= '0;
      r_p_ir  <= '0;
      r_vb    <= 1'b0;
      r_fb    <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
      o_valid <= 1'b0;
      o_first <= 1'b0;
    end else begin
      r_xr    <= i_x[2*DATA_W-1:DATA_W];
      r_xi    <= i_x[DATA_W-1:0];
      r_wr    <= i_w[2*TW_W-1:TW_W];
      r_wi    <= i_w[TW_W-1:0];
      r_va    <= i_valid;
      r_fa    <= i_first;
      r_p_rr  <= r_xr * r_wr;
      r_p_ii  <= r_xi * r_wi;
      r_p_ri  <= r_xr * r_wi;
      r_p_ir  <= r_xi * r_wr;
      r_vb    <= r_va;
      r_fb    <= r_fa;
      o_re    <= ACC_W'(w_re_sh);
      o_im    <= ACC_W'(w_im_sh);
      o_valid <= r_vb;
      o_first <= r_fb;
    end
  end

endmodule

// File: rtl/dft_mac_engine.sv
// Direct-DFT engine: walks n and (k*n) mod N for each bin, accumulates the
// rounded products, and hands each finished bin out on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one sample/twiddle address pair per cycle for bin k
// DRAIN | no new addresses; waiting for the last term to be accumulated
// OUT   | bin k presented on out_valid until out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module dft_mac_engine
  import dft_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TW_W      = TW_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                n_Reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   samp_number,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sample_addr,
  input  logic [2*DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0]   tw_addr,
  input  logic [2*TW_W-1:0]   tw_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*ACC_W-1:0]  out_data,
  output logic [ADDR_W-1:0]   out_bin
);

  if (ACC_W < DATA_W + TW_W + 1 - FRAC_BITS + ADDR_W) begin : g_acc_w_chk
    $error("dft_mac_engine: ACC_W too narrow for a full-length accumulation");
  end

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_len, r_k, r_n, r_tw;
  logic                     r_busy, r_done, r_out_valid;
  logic                     r_v1, r_f1;
  logic signed [ACC_W-1:0]  r_acc_re, r_acc_im;

  logic                     w_term_valid, w_term_first, w_cmul_busy;
  logic signed [ACC_W-1:0]  w_term_re, w_term_im;
  logic [ADDR_W:0]          w_tw_sum;
  logic [ADDR_W-1:0]        w_tw_next;
  logic                     w_last_n, w_last_k;

  cmul_round #(
    .DATA_W   (DATA_W),
    .TW_W     (TW_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_cmul (
    .clk    (clk),
    .n_Reset(n_Reset),
    .i_valid(r_v1),
    .i_first(r_f1),
    .i_x    (sample_data),
    .i_w    (tw_data),
    .o_valid(w_term_valid),
    .o_first(w_term_first),
    .o_busy (w_cmul_busy),
    .o_re   (w_term_re),
    .o_im   (w_term_im)
  );

  // Twiddle index steps by k; both operands are below N, so one subtract wraps it.
  assign w_tw_sum  = {1'b0, r_tw} + {1'b0, r_k};
  assign w_tw_next = (w_tw_sum >= {1'b0, r_len}) ? ADDR_W'(w_tw_sum - {1'b0, r_len})
                                                 : w_tw_sum[ADDR_W-1:0];
  assign w_last_n  = (r_n == r_len - ONE);
  assign w_last_k  = (r_k == r_len - ONE);

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_k         <= '0;
      r_n         <= '0;
      r_tw        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_v1        <= 1'b0;
      r_f1        <= 1'b0;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
    end else begin
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
      if (w_term_valid) begin
        r_acc_re <= w_term_first ? w_term_re : r_acc_re + w_term_re;
        r_acc_im <= w_term_first ? w_term_im : r_acc_im + w_term_im;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_len  <= samp_number;
            r_k    <= '0;
            r_n    <= '0;
            r_tw   <= '0;
            if (samp_number == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_v1 <= 1'b1;
          r_f1 <= (r_n == '0);
          if (w_last_n) begin
            r_state <= DRAIN;
          end else begin
            r_n  <= r_n + ONE;
            r_tw <= w_tw_next;
          end
        end
        DRAIN: begin
          // Only the final term is in flight once every earlier stage is empty.
          if (w_term_valid && !r_v1 && !w_cmul_busy) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_k) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_k     <= r_k + ONE;
              r_n     <= '0;
              r_tw    <= '0;
              r_state <= RUN;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign sample_addr = r_n;
  assign tw_addr     = r_tw;
  assign out_valid   = r_out_valid;
  assign out_data    = {r_acc_re, r_acc_im};
  assign out_bin     = r_k;

endmodule

// File: tb/tb_dft_mac_engine.sv
// Bench for dft_mac_engine: sync RAM/ROM models, a bin-by-bin DFT reference
// built from plain sums, and one negedge process checking every presented bin.
module tb_dft_mac_engine;
  import dft_pkg::*;

  localparam int DW  = 16;
  localparam int TWW = 16;
  localparam int FB  = 15;
  localparam int AW  = 36;
  localparam int ADW = 12;
  localparam longint HALF = longint'(1) <<< (FB - 1);

  logic              clk = 1'b0;
  logic              n_Reset = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b1;
  logic [ADW-1:0]    samp_number = '0;
  logic              busy, done, out_valid;
  logic [ADW-1:0]    sample_addr, tw_addr, out_bin;
  logic [2*DW-1:0]   sample_data = '0;
  logic [2*TWW-1:0]  tw_data = '0;
  logic [2*AW-1:0]   out_data;

  int xr[64], xi[64], tr[64], ti[64];
  cplx_t exp_q[$];
  int    exp_bin_q[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_ev = 0, exp_done_cyc = -1, done_cnt = 0;
  int frame_n = 0, rdy_mode = 0, hold_cnt = 0;
  bit prev_valid = 1'b0;

  dft_mac_engine dut (
    .clk        (clk),
    .n_Reset    (n_Reset),
    .start      (start),
    .samp_number(samp_number),
    .busy       (busy),
    .done       (done),
    .sample_addr(sample_addr),
    .sample_data(sample_data),
    .tw_addr    (tw_addr),
    .tw_data    (tw_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bin    (out_bin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read sample RAM and twiddle ROM, one cycle of latency.
  always @(posedge clk) begin
    sample_data <= {16'(xr[sample_addr[5:0]]), 16'(xi[sample_addr[5:0]])};
    tw_data     <= {16'(tr[tw_addr[5:0]]), 16'(ti[tw_addr[5:0]])};
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint rnd(input longint v);
    return (v + HALF) >>> FB;
  endfunction

  // X[k] = sum_n round(x[n] * tw[(k*n) mod N]).
  function automatic cplx_t model_bin(input int k, input int n);
    longint sr = 0, si = 0;
    cplx_t  e;
    for (int i = 0; i < n; i++) begin
      int m = (k * i) % n;
      sr += rnd(longint'(xr[i]) * tr[m] - longint'(xi[i]) * ti[m]);
      si += rnd(longint'(xr[i]) * ti[m] + longint'(xi[i]) * tr[m]);
    end
    e.re = AW'(sr);
    e.im = AW'(si);
    return e;
  endfunction

  always @(negedge clk) begin
    if (n_Reset) begin
      if (done) begin
        done_cnt++;
        chk("done_cycle", cyc, exp_done_cyc);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_result: out_valid with bin %0d, no result expected (cycle %0d)",
                   out_bin, cyc);
        end else begin
          chk("out_bin", out_bin, exp_bin_q[0]);
          chk("out_re", $signed(out_data[2*AW-1:AW]), exp_q[0].re);
          chk("out_im", $signed(out_data[AW-1:0]), exp_q[0].im);
          chk("sample_addr_hold", sample_addr, frame_n - 1);
          if (!prev_valid) chk("bin_latency", cyc - last_ev, frame_n + 5);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_bin_q.pop_front());
            last_ev = cyc;
            if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
          end
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: if (out_valid && out_bin == 1 && hold_cnt < 10) begin
           out_ready = 1'b0;
           hold_cnt++;
         end else begin
           out_ready = 1'b1;
         end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      xr[i] = int'($urandom_range(0, 65535)) - 32768;
      xi[i] = int'($urandom_range(0, 65535)) - 32768;
      tr[i] = int'($urandom_range(0, 65535)) - 32768;
      ti[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic set_quarter_twiddles();
    tr[0] = 32767;  ti[0] = 0;
    tr[1] = 0;      ti[1] = -32767;
    tr[2] = -32767; ti[2] = 0;
    tr[3] = 0;      ti[3] = 32767;
  endtask

  task automatic run_frame(input int n, input int mode, input bit extra_start);
    int d0, g;
    rdy_mode = mode;
    hold_cnt = 0;
    frame_n  = n;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_bin(k, n));
      exp_bin_q.push_back(k);
    end
    @(posedge clk); #1;
    start = 1'b1;
    samp_number = ADW'(n);
    last_ev = cyc;
    if (n == 0) exp_done_cyc = cyc + 1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    samp_number = ADW'($urandom_range(0, 4095));
    chk("busy_after_start", busy, 1);
    if (extra_start) begin
      @(posedge clk); #1;
      start = 1'b1;
      samp_number = ADW'(9);
      @(posedge clk); #1;
      start = 1'b0;
    end
    g = 0;
    while (done_cnt == d0 && g < 4000) begin
      @(posedge clk);
      g++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_timeout: no done after %0d cycles, required one for N=%0d", g, n);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("results_outstanding", exp_q.size(), 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    exp_q.delete();
    exp_bin_q.delete();
  endtask

  initial begin
    cplx_t e;
    int d0;

    #2 n_Reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data == '0, 1);
    chk("rst_addr", {sample_addr, tw_addr, out_bin} == '0, 1);
    repeat (2) @(posedge clk);
    #2 n_Reset = 1'b1;

    // single-sample frame
    xr[0] = 1000; xi[0] = 0; tr[0] = 32767; ti[0] = 0;
    e = model_bin(0, 1);
    chk("model_n1_re", e.re, 1000);
    chk("model_n1_im", e.im, 0);
    run_frame(1, 0, 1'b0);

    // impulse
    set_quarter_twiddles();
    for (int i = 0; i < 4; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 16384;
    e = model_bin(3, 4);
    chk("model_impulse_re", e.re, 16384);
    chk("model_impulse_im", e.im, 0);
    run_frame(4, 0, 1'b0);

    // DC input, exercising round-half-up of negative products
    for (int i = 0; i < 4; i++) begin xr[i] = 1000; xi[i] = 0; end
    chk("model_rnd_neg", rnd(-64'sd32767000), -1000);
    e = model_bin(0, 4);
    chk("model_dc_bin0", e.re, 4000);
    e = model_bin(1, 4);
    chk("model_dc_bin1", e.re, 0);
    run_frame(4, 0, 1'b0);

    // hold bin 1 for 10 cycles
    run_frame(4, 2, 1'b0);

    run_frame(0, 0, 1'b0);

    // second start during RUN is ignored
    fill_random(4);
    run_frame(4, 0, 1'b1);

    // reset mid-frame
    fill_random(8);
    frame_n = 8;
    @(posedge clk); #1;
    start = 1'b1;
    samp_number = ADW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    d0 = done_cnt;
    #3 n_Reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sample_addr", sample_addr, 0);
    chk("abort_tw_addr", tw_addr, 0);
    chk("abort_out", {out_data, out_bin} == '0, 1);
    repeat (3) @(posedge clk);
    #2 n_Reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    fill_random(4);
    run_frame(4, 0, 1'b0);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(1, 12);
      fill_random(n);
      run_frame(n, $urandom_range(0, 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
